// File: rtl/dvp_delta_pkg.sv
// dvp_delta_pkg: shared mode encodings, FSM states and sizing helpers for dvp_delta_capture
package dvp_delta_pkg;
  localparam logic MODE_SYNTH = 1'b0;
  localparam logic MODE_DVP   = 1'b1;
  localparam int DATA_WIDTH_DEF = 256;
  localparam int BYTES = DATA_WIDTH_DEF / 8;
  typedef enum logic {SYNC, ACTIVE} state_t;
  function automatic int bytes_for(input int dw);
    return dw / 8;
  endfunction
  function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
    return (x << (n % 32)) | (x >> ((32 - n % 32) % 32));
  endfunction
endpackage

// File: rtl/dvp_delta_capture_sync.sv
// dvp_sync: 2-flop synchroniser for the DVP pins with pclk/vsync rising-edge detect
//   clk, rst_n            system clock, async active-low reset
//   i_pclk/i_vsync/i_href/i_data  raw DVP pins
//   o_pclk_rise/o_vsync_rise      one-cycle edge strobes on synchronised pins
//   o_href/o_data                 synchronised pins, aligned with the strobes
module dvp_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_pclk,
  input  logic       i_vsync,
  input  logic       i_href,
  input  logic [7:0] i_data,
  output logic       o_pclk_rise,
  output logic       o_vsync_rise,
  output logic       o_href,
  output logic [7:0] o_data
);
  logic [10:0] r_s1, r_s2;
  logic r_pclk_d, r_vsync_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_pclk_d <= 1'b0;
      r_vsync_d <= 1'b0;
    end else begin
      r_s1 <= {i_pclk, i_vsync, i_href, i_data};
      r_s2 <= r_s1;
      r_pclk_d <= r_s2[10];
      r_vsync_d <= r_s2[9];
    end
  end
  assign o_pclk_rise = r_s2[10] & ~r_pclk_d;
  assign o_vsync_rise = r_s2[9] & ~r_vsync_d;
  assign o_href = r_s2[8];
  assign o_data = r_s2[7:0];
endmodule

// File: rtl/dvp_delta_capture.sv
// dvp_delta_capture: synthetic or DVP-hashed frame-delta source with valid/ready output slot
//   clk, rst_n                      system clock, async active-low reset
//   i_mode                          0 synthetic, 1 DVP capture
//   i_cam_pclk/vsync/href/data      raw DVP pins (async to clk)
//   o_delta_data/o_delta_valid      held frame delta; i_delta_ready accepts it
//   o_frame_count/o_drop_count      completed and dropped frame counters
//   o_synced                        first vsync seen in DVP mode
module dvp_delta_capture import dvp_delta_pkg::*; #(
  parameter int DATA_WIDTH = 256,
  parameter int FRAME_DIV  = 27_000,
  parameter int DROP_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_mode,
  input  logic                  i_cam_pclk,
  input  logic                  i_cam_vsync,
  input  logic                  i_cam_href,
  input  logic [7:0]            i_cam_data,
  output logic [DATA_WIDTH-1:0] o_delta_data,
  output logic                  o_delta_valid,
  input  logic                  i_delta_ready,
  output logic [31:0]           o_frame_count,
  output logic [DROP_W-1:0]     o_drop_count,
  output logic                  o_synced
);
  localparam int NB = bytes_for(DATA_WIDTH);
  localparam int PW = $clog2(NB);
  localparam int DV = $clog2(FRAME_DIV);
  logic w_pclk_rise, w_vs_rise, w_href;
  logic [7:0] w_data;
  dvp_sync u_sync (
    .clk(clk), .rst_n(rst_n),
    .i_pclk(i_cam_pclk), .i_vsync(i_cam_vsync), .i_href(i_cam_href), .i_data(i_cam_data),
    .o_pclk_rise(w_pclk_rise), .o_vsync_rise(w_vs_rise), .o_href(w_href), .o_data(w_data)
  );
  state_t r_state, w_state_nx;
  logic r_mode_q, r_tick;
  logic [DATA_WIDTH-1:0] r_acc, r_prev_hash, w_fold, w_syn, w_new;
  logic [PW-1:0] r_ptr;
  logic [DV-1:0] r_div;
  logic w_mode_chg, w_dvp, w_syn_mode, w_byte, w_done_dvp, w_done_syn, w_done, w_load, w_div_end;
  logic [31:0] w_fc;
  assign w_mode_chg = i_mode != r_mode_q;
  assign w_dvp = i_mode == MODE_DVP && !w_mode_chg;
  assign w_syn_mode = i_mode == MODE_SYNTH && !w_mode_chg;
  assign w_byte = w_dvp && r_state == ACTIVE && w_pclk_rise && w_href;
  assign w_done_dvp = w_dvp && r_state == ACTIVE && w_vs_rise;
  assign w_done_syn = w_syn_mode && r_tick;
  assign w_done = w_done_dvp || w_done_syn;
  assign w_load = w_done && (!o_delta_valid || i_delta_ready);
  assign w_div_end = r_div == DV'(FRAME_DIV - 1);
  assign w_fc = o_frame_count + 32'd1;
  // a byte landing in the same cycle as the closing vsync still belongs to the frame
  always_comb begin
    w_fold = r_acc;
    if (w_byte) w_fold[8*r_ptr +: 8] = r_acc[8*r_ptr +: 8] ^ w_data;
  end
  always_comb begin
    w_syn = '0;
    for (int i = 0; i < DATA_WIDTH / 32; i++) w_syn[32*i +: 32] = w_fc ^ rotl32(w_fc, 2*i + 1);
  end
  assign w_new = w_done_dvp ? (w_fold ^ r_prev_hash) : w_syn;
  always_comb begin
    w_state_nx = r_state;
    if (w_mode_chg) w_state_nx = SYNC;
    else if (w_dvp && r_state == SYNC && w_vs_rise) w_state_nx = ACTIVE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SYNC;
    else r_state <= w_state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q <= MODE_SYNTH;
      r_tick <= 1'b0;
      r_acc <= '0;
      r_ptr <= '0;
      r_prev_hash <= '0;
      r_div <= '0;
      o_delta_data <= '0;
      o_delta_valid <= 1'b0;
      o_frame_count <= '0;
      o_drop_count <= '0;
      o_synced <= 1'b0;
    end else begin
      r_mode_q <= i_mode;
      r_tick <= w_syn_mode && w_div_end;
      if (w_mode_chg || (w_dvp && w_vs_rise)) begin
        r_acc <= '0;
        r_ptr <= '0;
      end else if (w_byte) begin
        r_acc <= w_fold;
        r_ptr <= r_ptr == PW'(NB - 1) ? '0 : r_ptr + 1'b1;
      end
      if (w_mode_chg) r_div <= '0;
      else if (w_syn_mode) r_div <= w_div_end ? '0 : r_div + 1'b1;
      // prev_hash only tracks emitted frames so the consumer's XOR chain never breaks on a drop
      if (w_mode_chg) r_prev_hash <= '0;
      else if (w_load && w_done_dvp) r_prev_hash <= w_fold;
      if (w_mode_chg) o_synced <= 1'b0;
      else if (w_dvp && r_state == SYNC && w_vs_rise) o_synced <= 1'b1;
      if (w_mode_chg) o_frame_count <= '0;
      else if (w_done) o_frame_count <= w_fc;
      if (w_done && !w_load && o_drop_count != '1) o_drop_count <= o_drop_count + 1'b1;
      if (w_load) begin
        o_delta_data <= w_new;
        o_delta_valid <= 1'b1;
      end else if (o_delta_valid && i_delta_ready) o_delta_valid <= 1'b0;
    end
  end
endmodule
